alu_issue_ctrl: RTL and testbench

Command-side controller for the fixed-point ALU datapath. It accepts operation requests on a valid/ready stream and drives operands into the add/sub, multiply and divide units. It tracks every in-flight operation against each unit's fixed latency and returns tagged results on a single result port. It only accepts an operation whose completion slot is still free, so two results never reach the output in the same cycle.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_slot_tracker.sv | 58 +++++
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller.
package alu_pkg;

   typedef enum logic [1:0] {
      CmdAdd  = 2'b00,
      CmdSub  = 2'b01,
      CmdMult = 2'b10,
      CmdDiv  = 2'b11
   } alu_cmd_e;

   localparam int unsigned DefAddLat  = 1;
   localparam int unsigned DefMultLat = 2;
   localparam int unsigned DefDivLat  = 4;
   localparam int unsigned DefTagW    = 4;

   // Slot entries carry a tag field wide enough for any supported TAG_W.
   localparam int unsigned MaxTagW = 8;

   typedef struct packed {
      logic                valid;
      alu_cmd_e            cmd;
      logic [MaxTagW-1:0]  tag;
   } slot_entry_t;

   // Latency of the unit that executes a given command.
   function automatic int unsigned cmd_lat(alu_cmd_e c, int unsigned add_lat,
                                           int unsigned mult_lat, int unsigned div_lat);
      case (c)
         CmdMult: return mult_lat;
         CmdDiv:  return div_lat;
         default: return add_lat;
      endcase
   endfunction

endpackage

// File: rtl/alu_slot_tracker.sv
// Completion-slot reservation tracker: shift register of pending results,
// issue-ready computation and the rolling issue tag.
module alu_slot_tracker
   import alu_pkg::*;
#(
   parameter int unsigned AddLat  = DefAddLat,
   parameter int unsigned MultLat = DefMultLat,
   parameter int unsigned DivLat  = DefDivLat,
   parameter int unsigned TagW    = DefTagW
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  alu_cmd_e    cmd_i,
   input  logic        accept_i,
   output logic        ready_o,
   output slot_entry_t done_o
);

   localparam int unsigned MaxLat01 = (AddLat > MultLat) ? AddLat : MultLat;
   localparam int unsigned MaxLat   = (MaxLat01 > DivLat) ? MaxLat01 : DivLat;
   localparam int unsigned NumSlots = MaxLat + 1;
   localparam int unsigned SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

   slot_entry_t [NumSlots-1:0] resv_q, resv_d;
   slot_entry_t [NumSlots-1:0] resv_shift;
   logic [TagW-1:0]            tag_q, tag_d;
   logic [SlotIdxW-1:0]        lat_idx;

   // Target slot for the presented command and the vector as it looks after this edge's shift.
   assign lat_idx    = SlotIdxW'(cmd_lat(cmd_i, AddLat, MultLat, DivLat));
   assign resv_shift = resv_q >> $bits(slot_entry_t);

   // Ready depends only on the presented command and current reservations.
   assign ready_o = !resv_shift[lat_idx].valid;
   assign done_o  = resv_q[0];

   // Next-state: shift toward slot 0, then reserve the completion slot on accept.
   always_comb begin
      resv_d = resv_shift;
      tag_d  = tag_q;
      if (accept_i) begin
         resv_d[lat_idx] = '{valid: 1'b1, cmd: cmd_i, tag: MaxTagW'(tag_q)};
         tag_d           = tag_q + 1'b1;
      end
   end

   // Reservation and tag state; reset drops every pending reservation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resv_q <= '0;
         tag_q  <= '0;
      end else begin
         resv_q <= resv_d;
         tag_q  <= tag_d;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side controller for the fixed-point ALU: registers operands into
// the selected unit and returns tagged results on a single port.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned IN_WL    = 15,
   parameter int unsigned OUT_WL   = 16,
   parameter int unsigned ADD_LAT  = DefAddLat,
   parameter int unsigned MULT_LAT = DefMultLat,
   parameter int unsigned DIV_LAT  = DefDivLat,
   parameter int unsigned TAG_W    = DefTagW
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        cmd,
   input  logic [IN_WL-1:0]  a,
   input  logic [IN_WL-1:0]  b,
   output logic [IN_WL-1:0]  add_nsub_a,
   output logic [IN_WL-1:0]  add_nsub_b,
   output logic              add_or_sub,
   output logic [IN_WL-1:0]  mult_a,
   output logic [IN_WL-1:0]  mult_b,
   output logic [IN_WL-1:0]  div_a,
   output logic [IN_WL-1:0]  div_b,
   input  logic [OUT_WL-1:0] add_nsub_r,
   input  logic [OUT_WL-1:0] mult_r,
   input  logic [OUT_WL-1:0] div_r,
   output logic              res_valid,
   output logic [1:0]        res_cmd,
   output logic [TAG_W-1:0]  res_tag,
   output logic [OUT_WL-1:0] r
);

   alu_cmd_e    cmd_e;
   logic        accept;
   slot_entry_t done;

   logic [IN_WL-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
   logic              add_op_q, add_op_d;
   logic [IN_WL-1:0]  mult_a_q, mult_a_d, mult_b_q, mult_b_d;
   logic [IN_WL-1:0]  div_a_q, div_a_d, div_b_q, div_b_d;
   logic              res_valid_q, res_valid_d;
   logic [1:0]        res_cmd_q, res_cmd_d;
   logic [TAG_W-1:0]  res_tag_q, res_tag_d;
   logic [OUT_WL-1:0] r_q, r_d;
   logic              unused_tag_bits;

   assign cmd_e  = alu_cmd_e'(cmd);
   assign accept = in_valid & in_ready;

   alu_slot_tracker #(
      .AddLat  (ADD_LAT),
      .MultLat (MULT_LAT),
      .DivLat  (DIV_LAT),
      .TagW    (TAG_W)
   ) u_slot_tracker (
      .clk_i    (clk),
      .rst_ni   (rstb),
      .cmd_i    (cmd_e),
      .accept_i (accept),
      .ready_o  (in_ready),
      .done_o   (done)
   );

   // Only the selected unit's operands move on an accept; others hold steady.
   always_comb begin
      add_a_d  = add_a_q;
      add_b_d  = add_b_q;
      add_op_d = add_op_q;
      mult_a_d = mult_a_q;
      mult_b_d = mult_b_q;
      div_a_d  = div_a_q;
      div_b_d  = div_b_q;
      if (accept) begin
         unique case (cmd_e)
            CmdAdd, CmdSub: begin
               add_a_d  = a;
               add_b_d  = b;
               add_op_d = (cmd_e == CmdAdd);
            end
            CmdMult: begin
               mult_a_d = a;
               mult_b_d = b;
            end
            CmdDiv: begin
               div_a_d = a;
               div_b_d = b;
            end
         endcase
      end
   end

   // Result capture: slot 0 names the unit whose output is due this cycle.
   always_comb begin
      res_valid_d = done.valid;
      res_cmd_d   = res_cmd_q;
      res_tag_d   = res_tag_q;
      r_d         = r_q;
      if (done.valid) begin
         res_cmd_d = done.cmd;
         res_tag_d = done.tag[TAG_W-1:0];
         unique case (done.cmd)
            CmdAdd, CmdSub: r_d = add_nsub_r;
            CmdMult:        r_d = mult_r;
            CmdDiv:         r_d = div_r;
         endcase
      end
   end

   // Operand and result registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_op_q    <= 1'b0;
         mult_a_q    <= '0;
         mult_b_q    <= '0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_cmd_q   <= '0;
         res_tag_q   <= '0;
         r_q         <= '0;
      end else begin
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_op_q    <= add_op_d;
         mult_a_q    <= mult_a_d;
         mult_b_q    <= mult_b_d;
         div_a_q     <= div_a_d;
         div_b_q     <= div_b_d;
         res_valid_q <= res_valid_d;
         res_cmd_q   <= res_cmd_d;
         res_tag_q   <= res_tag_d;
         r_q         <= r_d;
      end
   end

   assign add_nsub_a = add_a_q;
   assign add_nsub_b = add_b_q;
   assign add_or_sub = add_op_q;
   assign mult_a     = mult_a_q;
   assign mult_b     = mult_b_q;
   assign div_a      = div_a_q;
   assign div_b      = div_b_q;
   assign res_valid  = res_valid_q;
   assign res_cmd    = res_cmd_q;
   assign res_tag    = res_tag_q;
   assign r          = r_q;

   // Tag bits above TAG_W are never set.
   assign unused_tag_bits = ^done.tag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with behavioural unit models and a
// due-time scoreboard of outstanding operations.
module tb_alu_issue_ctrl;

   localparam int IN_WL = 15, OUT_WL = 16, ADD_LAT = 1, MULT_LAT = 2, DIV_LAT = 4, TAG_W = 4;

   logic clk = 1'b0, rstb = 1'b0, in_valid = 1'b0, in_ready;
   logic [1:0] cmd = 2'b00;
   logic signed [IN_WL-1:0] a = '0, b = '0;
   logic signed [IN_WL-1:0] add_nsub_a, add_nsub_b, mult_a, mult_b, div_a, div_b;
   logic add_or_sub, res_valid;
   logic [OUT_WL-1:0] add_nsub_r, mult_r, div_r, r;
   logic [1:0] res_cmd;
   logic [TAG_W-1:0] res_tag;

   int checks = 0, failures = 0;

   alu_issue_ctrl #(.IN_WL(IN_WL), .OUT_WL(OUT_WL), .ADD_LAT(ADD_LAT), .MULT_LAT(MULT_LAT),
                    .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready), .cmd(cmd), .a(a), .b(b),
      .add_nsub_a(add_nsub_a), .add_nsub_b(add_nsub_b), .add_or_sub(add_or_sub),
      .mult_a(mult_a), .mult_b(mult_b), .div_a(div_a), .div_b(div_b),
      .add_nsub_r(add_nsub_r), .mult_r(mult_r), .div_r(div_r),
      .res_valid(res_valid), .res_cmd(res_cmd), .res_tag(res_tag), .r(r));

   always #5 clk = ~clk;

   // Arithmetic of the external units.
   function automatic logic [OUT_WL-1:0] f_addsub(logic signed [IN_WL-1:0] x, y, logic add);
      logic signed [OUT_WL-1:0] ex, ey;
      ex = OUT_WL'(x);
      ey = OUT_WL'(y);
      return add ? ex + ey : ex - ey;
   endfunction
   function automatic logic [OUT_WL-1:0] f_mult(logic signed [IN_WL-1:0] x, y);
      logic signed [2*IN_WL-1:0] p;
      p = x * y;
      return p[OUT_WL-1:0];
   endfunction
   function automatic logic [OUT_WL-1:0] f_div(logic signed [IN_WL-1:0] x, y);
      logic signed [OUT_WL-1:0] ex, ey;
      ex = OUT_WL'(x);
      ey = OUT_WL'(y);
      if (y == 0) return 16'hDEAD;
      return ex / ey;
   endfunction
   function automatic logic [OUT_WL-1:0] unit_result(logic [1:0] c, logic signed [IN_WL-1:0] x, y);
      case (c)
         2'd0: return f_addsub(x, y, 1'b1);
         2'd1: return f_addsub(x, y, 1'b0);
         2'd2: return f_mult(x, y);
         default: return f_div(x, y);
      endcase
   endfunction
   function automatic int lat_of(logic [1:0] c);
      case (c)
         2'd2: return MULT_LAT;
         2'd3: return DIV_LAT;
         default: return ADD_LAT;
      endcase
   endfunction

   // Unit pipelines, LAT stages each, fed from the controller's operand registers.
   logic [OUT_WL-1:0] add_p [ADD_LAT];
   logic [OUT_WL-1:0] mult_p [MULT_LAT];
   logic [OUT_WL-1:0] div_p [DIV_LAT];
   always @(posedge clk) begin
      add_p[0]  <= f_addsub(add_nsub_a, add_nsub_b, add_or_sub);
      mult_p[0] <= f_mult(mult_a, mult_b);
      div_p[0]  <= f_div(div_a, div_b);
      for (int i = 1; i < ADD_LAT; i++) add_p[i] <= add_p[i-1];
      for (int i = 1; i < MULT_LAT; i++) mult_p[i] <= mult_p[i-1];
      for (int i = 1; i < DIV_LAT; i++) div_p[i] <= div_p[i-1];
   end
   assign add_nsub_r = add_p[ADD_LAT-1];
   assign mult_r     = mult_p[MULT_LAT-1];
   assign div_r      = div_p[DIV_LAT-1];

   // Reference model: outstanding ops keyed by the edge after which they report.
   typedef struct {
      int               due;
      logic [1:0]       cmd;
      logic [TAG_W-1:0] tag;
      logic [OUT_WL-1:0] r;
   } exp_t;
   exp_t pend[$];
   int edge_cnt = 0;
   logic [TAG_W-1:0] m_tag = '0;
   logic signed [IN_WL-1:0] m_aa = '0, m_ab = '0, m_ma = '0, m_mb = '0, m_da = '0, m_db = '0;
   logic m_aos = 1'b0;
   logic [TAG_W-1:0] obs_tags[$];
   logic [OUT_WL-1:0] obs_r[$];

   task automatic step(input logic v, input logic [1:0] c, input logic signed [IN_WL-1:0] ia,
                       input logic signed [IN_WL-1:0] ib, output logic acc);
      logic exp_rdy;
      int lat, hit;
      exp_t x;
      in_valid = v; cmd = c; a = ia; b = ib;
      #1;
      lat = lat_of(c);
      exp_rdy = 1'b1;
      foreach (pend[i]) if (pend[i].due == edge_cnt + 1 + lat + 1) exp_rdy = 1'b0;
      checks++;
      if (in_ready !== exp_rdy) begin
         failures++;
         $display("FAIL in_ready edge=%0d cmd=%0d got=%b exp=%b", edge_cnt + 1, c, in_ready, exp_rdy);
      end
      acc = v && exp_rdy;
      if (acc) begin
         x.due = edge_cnt + 1 + lat + 1; x.cmd = c; x.tag = m_tag; x.r = unit_result(c, ia, ib);
         pend.push_back(x);
         m_tag++;
         if (c == 2'd2) begin m_ma = ia; m_mb = ib; end
         else if (c == 2'd3) begin m_da = ia; m_db = ib; end
         else begin m_aa = ia; m_ab = ib; m_aos = (c == 2'd0); end
      end
      @(posedge clk);
      edge_cnt++;
      #1;
      in_valid = 1'b0;
      checks++;
      if ({add_nsub_a, add_nsub_b, add_or_sub, mult_a, mult_b, div_a, div_b} !==
          {m_aa, m_ab, m_aos, m_ma, m_mb, m_da, m_db}) begin
         failures++;
         $display("FAIL operands edge=%0d got=%h/%h/%b %h/%h %h/%h exp=%h/%h/%b %h/%h %h/%h",
                  edge_cnt, add_nsub_a, add_nsub_b, add_or_sub, mult_a, mult_b, div_a, div_b,
                  m_aa, m_ab, m_aos, m_ma, m_mb, m_da, m_db);
      end
      hit = -1;
      foreach (pend[i]) if (pend[i].due == edge_cnt) hit = i;
      checks++;
      if (res_valid !== (hit >= 0)) begin
         failures++;
         $display("FAIL res_valid edge=%0d got=%b exp=%b", edge_cnt, res_valid, hit >= 0);
      end
      if (res_valid === 1'b1) begin
         obs_tags.push_back(res_tag);
         obs_r.push_back(r);
      end
      if (hit >= 0) begin
         checks++;
         if (r !== pend[hit].r || res_cmd !== pend[hit].cmd || res_tag !== pend[hit].tag) begin
            failures++;
            $display("FAIL result edge=%0d got r=%h cmd=%0d tag=%0d exp r=%h cmd=%0d tag=%0d",
                     edge_cnt, r, res_cmd, res_tag, pend[hit].r, pend[hit].cmd, pend[hit].tag);
         end
         pend.delete(hit);
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, acc);
   endtask

   // Issue a request and hold it until accepted, bounded.
   task automatic issue_held(input logic [1:0] c, input logic signed [IN_WL-1:0] ia, ib,
                             output int waits);
      logic acc;
      waits = 0;
      acc = 1'b0;
      while (!acc && waits < 10) begin
         step(1'b1, c, ia, ib, acc);
         if (!acc) waits++;
      end
      if (!acc) begin
         checks++; failures++;
         $display("FAIL hold_timeout cmd=%0d waited=%0d exp=accepted", c, waits);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if ({add_nsub_a, add_nsub_b, add_or_sub, mult_a, mult_b, div_a, div_b,
           res_valid, res_cmd, res_tag, r} !== '0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s got r=%h rv=%b tag=%0d ops=%h/%h/%h rdy=%b exp zeros rdy=1", name, r,
                  res_valid, res_tag, add_nsub_a, mult_a, div_a, in_ready);
      end
   endtask

   task automatic apply_reset();
      #2;
      rstb = 1'b0;
      #1;
      check_outputs_zero("reset_async");
      pend.delete();
      m_tag = '0;
      {m_aa, m_ab, m_aos, m_ma, m_mb, m_da, m_db} = '0;
      @(posedge clk);
      #1;
      rstb = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      for (int c = 0; c < 4; c++) begin
         cmd = 2'(c);
         #1;
         check_outputs_zero("reset_state");
      end
      @(posedge clk);
      #1;
      rstb = 1'b1;
      idle(2);
   endtask

   task automatic test_back_to_back();
      logic acc;
      int n_acc;
      obs_tags.delete();
      n_acc = 0;
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 2'd0, IN_WL'(i), 15'sd1, acc);
         if (acc) n_acc++;
      end
      idle(3);
      checks++;
      if (n_acc != 17 || obs_tags.size() != 17) begin
         failures++;
         $display("FAIL b2b_count got acc=%0d res=%0d exp 17/17", n_acc, obs_tags.size());
      end
      foreach (obs_tags[i]) begin
         checks++;
         if (obs_tags[i] !== TAG_W'(i % 16)) begin
            failures++;
            $display("FAIL b2b_tag idx=%0d got=%0d exp=%0d", i, obs_tags[i], i % 16);
         end
      end
   endtask

   task automatic test_add_sub();
      logic acc;
      obs_r.delete();
      step(1'b1, 2'd0, 15'sd5, 15'sd3, acc);
      idle(2);
      step(1'b1, 2'd1, -15'sd3, 15'sd4, acc);
      idle(2);
      checks++;
      if (obs_r.size() != 2 || obs_r[0] !== 16'd8 || obs_r[1] !== 16'hFFF9) begin
         failures++;
         $display("FAIL add_sub_values got n=%0d exp 8 and FFF9", obs_r.size());
      end
   endtask

   task automatic test_div_mult();
      logic acc;
      int w;
      obs_r.delete();
      step(1'b1, 2'd3, 15'sd100, 15'sd7, acc);
      step(1'b1, 2'd2, 15'sd12, -15'sd3, acc);
      checks++;
      if (acc !== 1'b1) begin
         failures++;
         $display("FAIL mult_after_div got acc=%b exp=1", acc);
      end
      issue_held(2'd2, 15'sd9, 15'sd9, w);
      idle(6);
      checks++;
      if (obs_r.size() != 3 || obs_r[0] !== 16'hFFDC || obs_r[1] !== 16'd14) begin
         failures++;
         $display("FAIL div_mult_order got n=%0d exp mult -36 before div 14", obs_r.size());
      end
   endtask

   task automatic test_collision();
      logic acc;
      int w;
      step(1'b1, 2'd3, 15'sd50, 15'sd5, acc);
      idle(2);
      issue_held(2'd0, 15'sd20, 15'sd22, w);
      checks++;
      if (w != 1) begin
         failures++;
         $display("FAIL collision_stall got waits=%0d exp=1", w);
      end
      step(1'b1, 2'd3, 15'sd7, 15'sd0, acc);
      idle(6);
   endtask

   task automatic test_random();
      logic acc;
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), IN_WL'($urandom),
              IN_WL'($urandom_range(0, 40)) - 15'sd20, acc);
      idle(6);
   endtask

   task automatic test_reset_mid();
      logic acc;
      step(1'b1, 2'd3, 15'sd90, 15'sd3, acc);
      step(1'b1, 2'd2, 15'sd4, 15'sd4, acc);
      apply_reset();
      idle(8);
      obs_tags.delete();
      step(1'b1, 2'd0, 15'sd1, 15'sd1, acc);
      idle(2);
      checks++;
      if (obs_tags.size() != 1 || obs_tags[0] !== '0) begin
         failures++;
         $display("FAIL post_reset_tag got n=%0d exp one result with tag 0", obs_tags.size());
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_add_sub();
      test_div_mult();
      test_collision();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
